// File: rtl/dc_axi_master.sv
// dc_axi_master
//   Bridges the data-cache line interface to a 32-bit AXI4 master port.
//   A 128-bit line write becomes a 4-beat INCR write burst (AW, W x4, B).
//   A line read becomes a 4-beat INCR read burst; the beats are packed into
//   one 128-bit line and presented for a single cycle.
//   The write and read channels are independent state machines.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   dcw_start_rq/in_addr/in_mask/in_data   line write request (mask bit 1 = byte off)
//   dcw_finish_wresp           one-cycle pulse after the write response
//   dcr_start_rq/rin_addr      line read request
//   rdat_m_data/rdat_m_valid   assembled read line and its one-cycle valid
//   finish_mrd                 one-cycle pulse, read burst complete
//   rqfull_1                   not used by the bridge
//   aw*/w*/b*                  AXI4 write address, data and response channels
//   ar*/r*                     AXI4 read address and data channels
//   bus_err                    sticky: error response or rlast/beat-count disagreement
//   req_drop                   sticky: start request arrived while its FSM was busy
module dc_axi_master #(
  parameter logic [3:0] ID_VAL = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  input  logic         rqfull_1,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic         bus_err,
  output logic         req_drop
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rstate_t;

  wstate_t      wstate;
  rstate_t      rstate;
  logic [1:0]   wcnt;
  logic [1:0]   rcnt;
  logic [27:0]  waddr;
  logic [27:0]  raddr;
  logic [15:0]  wmask;
  logic [127:0] wline;
  logic [95:0]  rbuf;

  // Line-offset address bits and rqfull_1 are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, rqfull_1, dcw_in_addr[3:0], dcr_rin_addr[3:0]};

  // Fixed burst shape: 4 beats of 4 bytes, incrementing, line aligned.
  assign awid    = ID_VAL;
  assign awaddr  = {waddr, 4'd0};
  assign awlen   = 8'd3;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;

  assign arid    = ID_VAL;
  assign araddr  = {raddr, 4'd0};
  assign arlen   = 8'd3;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Beat data is selected from the latched line by the registered beat
  // counter, so it cannot change while wvalid waits for wready.
  assign wdata = wline[{wcnt, 5'd0} +: 32];
  assign wstrb = ~wmask[{wcnt, 2'd0} +: 4];
  assign wlast = wvalid && (wcnt == 2'd3);

  // Write request capture: data registers carry no reset.
  always_ff @(posedge clk) begin
    if (wstate == W_IDLE && dcw_start_rq) begin
      waddr <= dcw_in_addr[31:4];
      wmask <= dcw_in_mask;
      wline <= dcw_in_data;
    end
  end

  // Write channel FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate           <= W_IDLE;
      wcnt             <= 2'd0;
      awvalid          <= 1'b0;
      wvalid           <= 1'b0;
      bready           <= 1'b0;
      dcw_finish_wresp <= 1'b0;
    end else begin
      dcw_finish_wresp <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (dcw_start_rq) begin
            awvalid <= 1'b1;
            wstate  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wcnt    <= 2'd0;
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wready) begin
            if (wcnt == 2'd3) begin
              wvalid <= 1'b0;
              bready <= 1'b1;
              wstate <= W_RESP;
            end else begin
              wcnt <= wcnt + 2'd1;
            end
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready           <= 1'b0;
            wcnt             <= 2'd0;
            dcw_finish_wresp <= 1'b1;
            wstate           <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read request capture and beat assembly: data registers carry no reset.
  // The final beat goes straight into rdat_m_data, so rbuf holds beats 0..2.
  always_ff @(posedge clk) begin
    if (rstate == R_IDLE && dcr_start_rq) begin
      raddr <= dcr_rin_addr[31:4];
    end
    if (rstate == R_DATA && rvalid) begin
      case (rcnt)
        2'd0:    rbuf[31:0]  <= rdata;
        2'd1:    rbuf[63:32] <= rdata;
        2'd2:    rbuf[95:64] <= rdata;
        default: ;
      endcase
    end
  end

  // Read channel FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate       <= R_IDLE;
      rcnt         <= 2'd0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      rdat_m_valid <= 1'b0;
      finish_mrd   <= 1'b0;
      rdat_m_data  <= 128'd0;
    end else begin
      rdat_m_valid <= 1'b0;
      finish_mrd   <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (dcr_start_rq) begin
            arvalid <= 1'b1;
            rstate  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            rcnt    <= 2'd0;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          // Termination is by beat count only; rlast is merely checked.
          if (rvalid) begin
            if (rcnt == 2'd3) begin
              rready       <= 1'b0;
              rdat_m_data  <= {rdata, rbuf};
              rdat_m_valid <= 1'b1;
              finish_mrd   <= 1'b1;
              rstate       <= R_DONE;
            end else begin
              rcnt <= rcnt + 2'd1;
            end
          end
        end
        R_DONE: begin
          rcnt   <= 2'd0;
          rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err  <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      if ((bvalid && bready && bresp != 2'b00) ||
          (rvalid && rready && (rresp != 2'b00 || rlast != (rcnt == 2'd3)))) begin
        bus_err <= 1'b1;
      end
      if ((dcw_start_rq && wstate != W_IDLE) ||
          (dcr_start_rq && rstate != R_IDLE)) begin
        req_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dc_axi_master.sv
module tb_dc_axi_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dcw_start_rq;
  logic [31:0]  dcw_in_addr;
  logic [15:0]  dcw_in_mask;
  logic [127:0] dcw_in_data;
  logic         dcw_finish_wresp;
  logic         dcr_start_rq;
  logic [31:0]  dcr_rin_addr;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid;
  logic         finish_mrd;
  logic         rqfull_1;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic         bus_err;
  logic         req_drop;

  dc_axi_master #(.ID_VAL(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr), .dcw_in_mask(dcw_in_mask),
    .dcw_in_data(dcw_in_data), .dcw_finish_wresp(dcw_finish_wresp),
    .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr),
    .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
    .rqfull_1(rqfull_1),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues
  logic [31:0]  exp_aw[$];
  logic [31:0]  exp_ar[$];
  logic [36:0]  exp_w[$];
  logic [127:0] exp_line[$];
  int           exp_wfin[$];
  int           exp_rfin[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Responder controls
  int          aw_stall;
  int          w_stall_beat;
  int          w_stall_n;
  int          r_gap;
  int          r_gapc;
  int          r_err_beat;
  int          r_idx;
  int          w_beat;
  logic [31:0] r_data[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  // AW responder: hold awready low for aw_stall cycles of awvalid.
  initial begin
    awready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (awvalid && aw_stall > 0) begin
        awready = 1'b0;
        aw_stall--;
      end else begin
        awready = 1'b1;
      end
    end
  end

  // W responder: stall beat w_stall_beat for w_stall_n cycles.
  initial begin
    wready = 1'b1;
    w_beat = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) w_beat = 0;
      else if (wvalid && wready) w_beat = wlast ? 0 : w_beat + 1;
      #1;
      if (wvalid && w_beat == w_stall_beat && w_stall_n > 0) begin
        wready = 1'b0;
        w_stall_n--;
      end else begin
        wready = 1'b1;
      end
    end
  end

  // B responder: answer OKAY as soon as bready is up.
  initial begin
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      bvalid = bready && rst_n;
    end
  end

  // R responder: r_gap idle cycles before every beat.
  initial begin
    rvalid = 1'b0;
    rdata  = 32'd0;
    rresp  = 2'b00;
    rlast  = 1'b0;
    r_idx  = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        r_idx = 0;
      end else if (rvalid && rready) begin
        r_idx  = (r_idx == 3) ? 0 : r_idx + 1;
        r_gapc = r_gap;
      end
      #1;
      if (rst_n && rready) begin
        if (r_gapc > 0) begin
          rvalid = 1'b0;
          r_gapc--;
        end else begin
          rvalid = 1'b1;
          rdata  = r_data[r_idx];
          rresp  = (r_idx == r_err_beat) ? 2'b10 : 2'b00;
          rlast  = (r_idx == 3);
        end
      end else begin
        rvalid = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake or pulse.
  initial begin
    logic [36:0] pw;
    logic [31:0] pa;
    logic        pws;
    logic        pas;
    int          last_rb;
    int          e;
    pws = 1'b0; pas = 1'b0; last_rb = -100; pw = '0; pa = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pws = 1'b0;
        pas = 1'b0;
      end else begin
        if (pas) chk("aw_stable", 128'({awvalid, awaddr}), 128'({1'b1, pa}));
        if (pws) chk("w_stable", 128'({wvalid, wdata, wstrb, wlast}), 128'({1'b1, pw}));
        pas = awvalid && !awready;
        pa  = awaddr;
        pws = wvalid && !wready;
        pw  = {wdata, wstrb, wlast};
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) unexp("aw");
          else chk("aw", 128'({awid, awlen, awsize, awburst, awaddr}),
                   128'({4'd0, 8'd3, 3'b010, 2'b01, exp_aw.pop_front()}));
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) unexp("w_beat");
          else chk("w_beat", 128'({wdata, wstrb, wlast}), 128'(exp_w.pop_front()));
        end
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) unexp("ar");
          else chk("ar", 128'({arid, arlen, arsize, arburst, araddr}),
                   128'({4'd0, 8'd3, 3'b010, 2'b01, exp_ar.pop_front()}));
        end
        if (rvalid && rready) last_rb = cyc;
        if (rdat_m_valid) begin
          chk("rd_after_last_beat", 128'(cyc), 128'(last_rb + 1));
          chk("finish_mrd_with_valid", 128'(finish_mrd), 128'(1'b1));
          if (exp_line.size() == 0) unexp("rline");
          else chk("rline", rdat_m_data, exp_line.pop_front());
          if (exp_rfin.size() == 0) unexp("rd_cycle");
          else begin
            e = exp_rfin.pop_front();
            if (e >= 0) chk("rd_cycle", 128'(cyc), 128'(e));
          end
        end else if (finish_mrd) begin
          unexp("finish_mrd_alone");
        end
        if (dcw_finish_wresp) begin
          if (exp_wfin.size() == 0) unexp("wr_cycle");
          else begin
            e = exp_wfin.pop_front();
            if (e >= 0) chk("wr_cycle", 128'(cyc), 128'(e));
          end
        end
      end
    end
  end

  // Stimulus helpers; callers sit 1 time unit after a rising edge.
  task automatic start_write(input logic [31:0] a, input logic [15:0] m,
                             input logic [127:0] d, input int fin);
    dcw_start_rq = 1'b1;
    dcw_in_addr  = a;
    dcw_in_mask  = m;
    dcw_in_data  = d;
    exp_aw.push_back({a[31:4], 4'h0});
    for (int k = 0; k < 4; k++) exp_w.push_back({d[32*k +: 32], ~m[4*k +: 4], k == 3});
    exp_wfin.push_back(cyc + fin);
  endtask

  task automatic start_read(input logic [31:0] a, input logic [127:0] line,
                            input int fin, input bit completes);
    dcr_start_rq = 1'b1;
    dcr_rin_addr = a;
    for (int k = 0; k < 4; k++) r_data[k] = line[32*k +: 32];
    r_gapc = r_gap;
    exp_ar.push_back({a[31:4], 4'h0});
    if (completes) begin
      exp_line.push_back(line);
      exp_rfin.push_back(cyc + fin);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dcw_start_rq = 1'b0;
    dcr_start_rq = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_wfin.size() != 0 || exp_rfin.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d write and %0d read completions outstanding",
               exp_wfin.size(), exp_rfin.size());
      exp_aw.delete(); exp_w.delete(); exp_ar.delete();
      exp_line.delete(); exp_wfin.delete(); exp_rfin.delete();
    end
    tick();
    tick();
  endtask

  task automatic check_flag(input string name, input logic act, input logic exp);
    @(negedge clk);
    chk(name, 128'(act), 128'(exp));
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    dcw_start_rq = 1'b0; dcw_in_addr = '0; dcw_in_mask = '0; dcw_in_data = '0;
    dcr_start_rq = 1'b0; dcr_rin_addr = '0; rqfull_1 = 1'b0;
    arready = 1'b1;
    aw_stall = 0; w_stall_beat = 0; w_stall_n = 0;
    r_gap = 0; r_gapc = 0; r_err_beat = 9;
    for (int k = 0; k < 4; k++) r_data[k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_handshakes", 128'({awvalid, wvalid, bready, arvalid, rready}), 128'(5'b0));
    chk("reset_pulses_flags",
        128'({dcw_finish_wresp, rdat_m_valid, finish_mrd, bus_err, req_drop}), 128'(5'b0));
    chk("reset_rdat", rdat_m_data, 128'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Basic write, all readies high
    start_write(32'h0000_1238, 16'h0000,
                128'h44444444_33333333_22222222_11111111, 7);
    tick();
    wait_done(60);

    // Read with two idle cycles before every beat
    r_gap = 2;
    start_read(32'h8000_0040, 128'h000000A3_000000A2_000000A1_000000A0, 14, 1'b1);
    tick();
    wait_done(60);
    r_gap = 0;

    // Masked write, beat 1 stalled for 3 cycles
    w_stall_beat = 1; w_stall_n = 3;
    start_write(32'h2000_0010, 16'h00F0,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 10);
    tick();
    wait_done(60);

    // Concurrent write and read, awready held off for 5 cycles
    aw_stall = 5;
    start_write(32'h0000_0100, 16'h0000,
                128'h0F0F0F0F_12345678_CAFEBABE_DEADBEEF, 12);
    start_read(32'h0000_0200, 128'h000000B3_000000B2_000000B1_000000B0, 6, 1'b1);
    tick();
    wait_done(60);

    // Second write request while the first is in its data phase
    w_stall_beat = 0; w_stall_n = 4;
    start_write(32'h0000_3000, 16'h0000,
                128'h77777777_66666666_55555555_EEEEEEEE, 11);
    tick();
    tick();
    dcw_start_rq = 1'b1;
    dcw_in_addr  = 32'h0000_4000;
    dcw_in_data  = 128'h99999999_99999999_99999999_99999999;
    dcw_in_mask  = 16'hFFFF;
    tick();
    check_flag("req_drop_set", req_drop, 1'b1);
    wait_done(60);
    check_flag("bus_err_clean", bus_err, 1'b0);

    // Read with an error response on beat 1: line still delivered
    r_err_beat = 1;
    start_read(32'h0000_0400, 128'h000000C3_000000C2_000000C1_000000C0, 6, 1'b1);
    tick();
    wait_done(60);
    r_err_beat = 9;
    check_flag("bus_err_set", bus_err, 1'b1);
    check_flag("req_drop_sticky", req_drop, 1'b1);

    // Reset while beat 2 of a read is on the bus
    start_read(32'h0000_0500, 128'h000000E3_000000E2_000000E1_000000E0, 0, 1'b0);
    tick();
    n = 0;
    while (r_idx != 2 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL reset_test_wait: beat 2 never reached, r_idx %0d required 2", r_idx);
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_handshakes", 128'({awvalid, wvalid, bready, arvalid, rready}), 128'(5'b0));
    chk("rst_mid_flags",
        128'({dcw_finish_wresp, rdat_m_valid, finish_mrd, bus_err, req_drop}), 128'(5'b0));
    chk("rst_mid_rdat", rdat_m_data, 128'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    tick();
    start_read(32'h0000_0600, 128'h000000F3_000000F2_000000F1_000000F0, 6, 1'b1);
    tick();
    wait_done(60);

    chk("left_aw", 128'(exp_aw.size()), 128'(0));
    chk("left_w", 128'(exp_w.size()), 128'(0));
    chk("left_ar", 128'(exp_ar.size()), 128'(0));
    chk("left_line", 128'(exp_line.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
